// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave: oversampled SCL/SDA, fixed 7-bit address, ACKed data bytes as strobes.
// Optional glitch filter on scl_s/sda_s enabled by defining I2C_SLAVE_FILTER_EN.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h5D,
    parameter int unsigned MAX_BYTES  = 16,
    parameter int unsigned FILT_LEN   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       frame_start,
    output logic       frame_stop,
    output logic       busy
);

    localparam int unsigned BCW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_s, sda_s, scl_q, sda_q;

    // 2-FF synchronizers, preset high to match an idle bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    logic [7:0] scl_cnt, sda_cnt;
    logic       scl_f, sda_f;

    // Filtered level follows the synchronized input only after FILT_LEN stable cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= 8'd0;
            sda_cnt <= 8'd0;
        end else begin
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= 8'd0;
            end else if (scl_cnt == 8'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= 8'd0;
            end else begin
                scl_cnt <= scl_cnt + 8'd1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= 8'd0;
            end else if (sda_cnt == 8'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= 8'd0;
            end else begin
                sda_cnt <= sda_cnt + 8'd1;
            end
        end
    end

    assign scl_s = scl_f;
    assign sda_s = sda_f;
`else
    logic unused_filt_len;
    assign unused_filt_len = |8'(FILT_LEN);
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    state_t         state, state_d;
    logic [6:0]     shift, shift_d;
    logic [2:0]     bit_cnt, bit_cnt_d;
    logic [BCW-1:0] byte_cnt, byte_cnt_d;
    logic           ack_ok, ack_ok_d;
    logic           ack_drv, ack_drv_d;
    logic           sda_oe, sda_oe_d;
    logic [7:0]     rx_data_d;
    logic           rx_valid_d, rx_first_d, frame_start_d, frame_stop_d, busy_d;
    logic [7:0]     byte_w;

    assign byte_w = {shift, sda_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift       <= 7'd0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= '0;
            ack_ok      <= 1'b0;
            ack_drv     <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            frame_start <= 1'b0;
            frame_stop  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            shift       <= shift_d;
            bit_cnt     <= bit_cnt_d;
            byte_cnt    <= byte_cnt_d;
            ack_ok      <= ack_ok_d;
            ack_drv     <= ack_drv_d;
            sda_oe      <= sda_oe_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            rx_first    <= rx_first_d;
            frame_start <= frame_start_d;
            frame_stop  <= frame_stop_d;
            busy        <= busy_d;
        end
    end

    // Bus conditions take priority over bit handling; SDA only changes on scl_s falls
    always_comb begin
        state_d       = state;
        shift_d       = shift;
        bit_cnt_d     = bit_cnt;
        byte_cnt_d    = byte_cnt;
        ack_ok_d      = ack_ok;
        ack_drv_d     = ack_drv;
        sda_oe_d      = sda_oe;
        rx_data_d     = rx_data;
        rx_valid_d    = 1'b0;
        rx_first_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_stop_d  = 1'b0;
        busy_d        = busy;

        if (stop_det) begin
            state_d      = IDLE;
            sda_oe_d     = 1'b0;
            frame_stop_d = busy;
            busy_d       = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_w[6:0];
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_w == {SLAVE_ADDR, 1'b0}) begin
                                state_d       = ADDR_ACK;
                                frame_start_d = 1'b1;
                                busy_d        = 1'b1;
                                byte_cnt_d    = '0;
                                ack_ok_d      = 1'b1;
                                ack_drv_d     = 1'b0;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            ack_drv_d = 1'b1;
                            sda_oe_d  = ack_ok;
                        end else begin
                            ack_drv_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_w[6:0];
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_d   = DATA_ACK;
                            ack_drv_d = 1'b0;
                            if (byte_cnt < BCW'(MAX_BYTES)) begin
                                rx_data_d  = byte_w;
                                rx_valid_d = 1'b1;
                                rx_first_d = (byte_cnt == '0);
                                byte_cnt_d = byte_cnt + BCW'(1);
                                ack_ok_d   = 1'b1;
                            end else begin
                                ack_ok_d = 1'b0;
                            end
                        end
                    end
                end
                IDLE, IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master, directed and random frames vs a frame-level model.
module tb_i2c_slave_rx;

    localparam int unsigned Q    = 20;
    localparam int unsigned MAXB = 2;
    localparam logic [7:0]  OWN  = 8'hBA;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       m_low;
    wire        sda_w;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, frame_start, frame_stop, busy;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    i2c_slave_rx #(.SLAVE_ADDR(7'h5D), .MAX_BYTES(MAXB), .FILT_LEN(8)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda_w),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .frame_start(frame_start), .frame_stop(frame_stop), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_fs = 0, n_fp = 0, n_rx = 0, n_drive = 0, n_busy = 0;
    logic [8:0] rx_log [0:255];

    always @(negedge clk) begin
        if (frame_start) n_fs++;
        if (frame_stop)  n_fp++;
        if (busy)        n_busy++;
        if (sda_w === 1'b0 && !m_low) n_drive++;
        if (rx_valid) begin
            rx_log[n_rx[7:0]] = {rx_first, rx_data};
            n_rx++;
        end
    end

    int         errors = 0, checks = 0;
    int         fs0, fp0, rx0, drv0, busy0;
    logic [7:0] tx [0:7];
    logic       ack_got [0:8];
    logic       a_tmp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic snap();
        fs0 = n_fs; fp0 = n_fp; rx0 = n_rx; drv0 = n_drive; busy0 = n_busy;
    endtask

    task automatic m_start();
        m_low = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        m_low = 1'b1; wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic m_stop();
        m_low = 1'b1; wq(Q);
        scl = 1'b1;   wq(Q);
        m_low = 1'b0; wq(Q);
    endtask

    task automatic write_bit(input logic b, input bit glitch);
        m_low = ~b; wq(Q);
        scl = 1'b1;
        if (glitch) begin
            wq(15); scl = 1'b0; wq(5); scl = 1'b1; wq(20);
        end else begin
            wq(2 * Q);
        end
        scl = 1'b0; wq(Q);
    endtask

    task automatic read_ack(output logic a);
        m_low = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        a = sda_w;    wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(b[i], i == glitch_bit);
        read_ack(a);
    endtask

    task automatic do_frame(input logic [7:0] addr, input int n);
        m_start();
        write_byte(addr, -1, ack_got[0]);
        for (int i = 0; i < n; i++) write_byte(tx[i], -1, ack_got[i + 1]);
        m_stop();
        wq(Q);
    endtask

    // Frame-level model: ACK only our write address, ACK/strobe the first MAXB bytes
    task automatic check_frame(input string tag, input logic [7:0] addr, input int n);
        bit match;
        int nstr;
        match = (addr == OWN);
        nstr  = match ? ((n < int'(MAXB)) ? n : int'(MAXB)) : 0;
        check($sformatf("%s addr_ack", tag), 32'(ack_got[0]), 32'(!match));
        for (int i = 0; i < n; i++)
            check($sformatf("%s data_ack%0d", tag, i), 32'(ack_got[i + 1]),
                  32'(!(match && i < int'(MAXB))));
        check($sformatf("%s frame_start", tag), 32'(n_fs - fs0), match ? 32'd1 : 32'd0);
        check($sformatf("%s frame_stop", tag), 32'(n_fp - fp0), match ? 32'd1 : 32'd0);
        check($sformatf("%s strobes", tag), 32'(n_rx - rx0), 32'(nstr));
        for (int j = 0; j < nstr; j++)
            check($sformatf("%s rx%0d", tag, j), 32'(rx_log[8'(rx0 + j)]), 32'({j == 0, tx[j]}));
        if (!match) begin
            check($sformatf("%s no_drive", tag), 32'(n_drive - drv0), 32'd0);
            check($sformatf("%s busy_low", tag), 32'(n_busy - busy0), 32'd0);
        end
        check($sformatf("%s busy_after", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; scl = 1'b1; m_low = 1'b0;
        wq(5);
        @(negedge clk);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset strobes", 32'({rx_valid, rx_first, frame_start, frame_stop, busy}), 32'd0);
        check("reset sda", 32'(sda_w), 32'd1);
        reset = 1'b0;
        wq(5);

        // Nominal write
        tx[0] = 8'h12; tx[1] = 8'h34;
        snap();
        do_frame(OWN, 2);
        check_frame("nominal", OWN, 2);
        check("nominal busy_seen", 32'(n_busy - busy0 > 0), 32'd1);

        // Wrong address
        tx[0] = 8'h55;
        snap(); do_frame(8'hB8, 1); check_frame("wrong_addr", 8'hB8, 1);

        // Read attempt
        snap(); do_frame(8'hBB, 0); check_frame("read", 8'hBB, 0);

        // Overflow past MAXB
        tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03;
        snap(); do_frame(OWN, 3); check_frame("overflow", OWN, 3);

        // Repeated START aborting a partial byte
        snap();
        m_start();
        write_byte(OWN, -1, ack_got[0]);
        write_byte(8'hAA, -1, ack_got[1]);
        write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0); write_bit(1'b1, 1'b0);
        m_start();
        write_byte(OWN, -1, ack_got[2]);
        write_byte(8'h5C, -1, ack_got[3]);
        m_stop(); wq(Q);
        for (int i = 0; i < 4; i++) check($sformatf("rstart ack%0d", i), 32'(ack_got[i]), 32'd0);
        check("rstart frame_start", 32'(n_fs - fs0), 32'd2);
        check("rstart frame_stop", 32'(n_fp - fp0), 32'd1);
        check("rstart strobes", 32'(n_rx - rx0), 32'd2);
        check("rstart rx0", 32'(rx_log[8'(rx0)]), 32'h1AA);
        check("rstart rx1", 32'(rx_log[8'(rx0 + 1)]), 32'h15C);

        // Random frames
        for (int k = 0; k < 6; k++) begin
            logic [7:0] addr;
            int n;
            n = int'($urandom_range(0, 4));
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    addr = OWN;
                2:       addr = {7'($urandom), 1'b0};
                default: addr = 8'hBB;
            endcase
            snap(); do_frame(addr, n);
            check_frame($sformatf("rand%0d", k), addr, n);
        end

        // Asynchronous reset while the ACK is being driven
        tx[0] = 8'h66;
        m_start();
        write_byte(OWN, -1, a_tmp);
        for (int i = 7; i >= 0; i--) write_bit(tx[0][i], 1'b0);
        m_low = 1'b0; wq(Q);
        check("ack before reset", 32'(sda_w), 32'd0);
        @(negedge clk); #2;
        reset = 1'b1; #1;
        check("reset sda released", 32'(sda_w), 32'd1);
        check("reset mid rx_data", 32'(rx_data), 32'd0);
        check("reset mid outputs", 32'({rx_valid, rx_first, frame_start, frame_stop, busy}), 32'd0);
        wq(3); reset = 1'b0;
        scl = 1'b1; wq(Q); scl = 1'b0; wq(Q);
        m_stop(); wq(Q);
        tx[0] = 8'h77;
        snap(); do_frame(OWN, 1); check_frame("after_reset", OWN, 1);

`ifdef I2C_SLAVE_FILTER_EN
        // Short SCL low glitch mid-bit must be rejected
        tx[0] = 8'h12;
        snap();
        m_start();
        write_byte(OWN, -1, ack_got[0]);
        write_byte(8'h12, 3, ack_got[1]);
        m_stop(); wq(Q);
        check_frame("glitch", OWN, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Write-only I2C slave (responder) for the FPGA fabric, running from the 27 MHz pixel clock. It oversamples SCL/SDA, detects START/STOP, matches a fixed 7-bit address and ACKs it, then ACKs and delivers received data bytes as single-cycle strobes. Its bus behaviour is compatible with the team's 5 kHz bit-banged master and with external masters up to 100 kHz.

## Interface
- `SLAVE_ADDR`, default 7'h5D: 7-bit address this block answers to.
- `MAX_BYTES`, default 16: data bytes ACKed per frame. Bytes after this count are NACKed.
- `FILT_LEN`, default 8: glitch-filter stability length in clk cycles. Range 2–255. Used only with the filter macro.
- `clk` input 1: 27 MHz system clock.
- `reset` input 1: asynchronous, active-high reset.
- `scl` input 1: I2C SCL. This block never drives it and never clock-stretches.
- `sda` inout 1: I2C SDA, open-drain. The block either drives 0 or leaves it at 'z'; a pull-up is required.
- `rx_data` output 8: last received data byte, MSB first on the wire.
- `rx_valid` output 1: one-cycle strobe; `rx_data` is valid on this cycle.
- `rx_first` output 1: high together with `rx_valid` for the first data byte of a frame.
- `frame_start` output 1: one-cycle pulse when an address match is ACKed.
- `frame_stop` output 1: one-cycle pulse on STOP ending a matched frame.
- `busy` output 1: high from address match until STOP or START.

## Operation
- **Input conditioning.** SCL and SDA each pass through a 2-FF synchronizer, then an optional filter, giving `scl_s` and `sda_s`. Edges are detected on `scl_s`/`sda_s` versus their previous-cycle values.
- **START.** `sda_s` falls while `scl_s` = 1. The FSM goes to ADDR from any state, which covers repeated START.
- **STOP.** `sda_s` rises while `scl_s` = 1. The FSM goes to IDLE from any state and SDA is released.
- **Bit sampling.** Address and data bits are sampled on each `scl_s` rising edge and shifted in MSB first. A 3-bit counter counts bits.
- **States:** IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- **ADDR.** After 8 bits, the byte is compared against {SLAVE_ADDR, 0}.
  - Match: go to ADDR_ACK. Pulse `frame_start`, set `busy`, clear the byte counter.
  - Mismatch, or R/W = 1 (reads unsupported): go to IGNORE and do not drive SDA.
- **ACK slot (ADDR_ACK / DATA_ACK).**
  - On the `scl_s` falling edge after the 8th bit, drive SDA low (ACK) or leave it released (NACK).
  - Hold through the 9th SCL high period.
  - Release on the next `scl_s` falling edge, then go to DATA.
- **DATA.** After the 8th bit of a byte:
  - If the byte counter < MAX_BYTES: register `rx_data`, pulse `rx_valid` (plus `rx_first` if the counter is 0), increment the counter, go to DATA_ACK with ACK.
  - Otherwise: no strobe, go to DATA_ACK with NACK.
  - The byte counter saturates at MAX_BYTES.
- **IGNORE.** Waits for START or STOP only. SDA stays released.
- **Partial byte.** STOP or START mid-byte discards the partial byte with no strobe. `frame_stop` pulses only if `busy` was high.
- **Own-drive safety.** SDA is only changed while `scl_s` = 0, so the block's own ACK drive never creates false START/STOP.

## Timing
- **Reset values:** `rx_data` = 0, `rx_valid` = `rx_first` = `frame_start` = `frame_stop` = `busy` = 0, SDA released, FSM in IDLE, synchronizers preset to 1.
- **Pin-to-internal latency:** 2 cycles without the filter; 2 + FILT_LEN cycles with it.
- **Strobe timing:** `rx_valid` is asserted on the cycle after the 8th-bit `scl_s` rising edge is detected. `rx_data` holds until the next strobe.
- **`frame_start`:** pulses on the same cycle the address decision is made, one cycle after the 8th address-bit edge.
- **ACK drive:** SDA goes low one cycle after the `scl_s` falling-edge detect. That is 3 cycles (≈111 ns) after the pin without the filter, which is within the 100 kHz tHD;DAT limit.
- **Simultaneous START/STOP and SCL edge:** cannot occur, since START/STOP require `scl_s` high and stable. START/STOP detection takes priority over bit handling.
- **Asynchronous reset mid-frame:** SDA is released immediately (combinational from the FF). The bus recovers at the master's next START.

## Configuration
- **`I2C_SLAVE_FILTER_EN` defined:** each of `scl_s`/`sda_s` updates only after the synchronized input has been stable for FILT_LEN consecutive cycles. Pulses shorter than FILT_LEN cycles are rejected.
- **`I2C_SLAVE_FILTER_EN` undefined:** `scl_s`/`sda_s` are the direct 2-FF synchronizer outputs, and FILT_LEN is ignored.

## Test plan
- **Nominal write.** Master at 5 kHz sends START, 0xBA, 0x12, 0x34, STOP.
  - Three ACKs on SDA.
  - `frame_start` ×1.
  - `rx_valid` ×2 with `rx_data` 0x12 (`rx_first` = 1), then 0x34 (`rx_first` = 0).
  - `frame_stop` ×1.
- **Wrong address.** START, 0xB8, 0x55, STOP.
  - SDA never driven.
  - No `rx_valid`, `frame_start` or `frame_stop`.
  - `busy` stays 0.
- **Read attempt.** START, 0xBB, STOP → address NACKed, no strobes.
- **Overflow.** MAX_BYTES = 2; send 0xBA, 0x01, 0x02, 0x03.
  - 0x01 and 0x02 are ACKed and strobed.
  - 0x03 is NACKed with no strobe.
- **Repeated START and abort.** START, 0xBA, 0xAA, then repeated START after 4 bits, then 0xBA, 0x5C, STOP.
  - One strobe of 0xAA.
  - Partial byte discarded.
  - `frame_start` ×2, strobe of 0x5C with `rx_first` = 1, `frame_stop` ×1.
- **Reset and glitch.**
  - Assert `reset` during an ACK slot → SDA released within the same cycle, all outputs 0.
  - With `I2C_SLAVE_FILTER_EN` and FILT_LEN = 8, inject a 5-cycle SCL low glitch mid-bit → no extra bit shifted, and 0x12 is still received correctly.
